// File: rtl/vga_sram_arbiter.sv
// Shares one async SRAM between the VGA pixel-fetch read port and the source R/W port.
// VGA has priority; the source cannot be passed over more than VGA_MAX_STREAK times in a row.
module vga_sram_arbiter #(
    parameter int SRAM_AW        = 18,
    parameter int SRAM_DW        = 16,
    parameter int ACCESS_CYCLES  = 2,
    parameter int VGA_MAX_STREAK = 4
) (
    input  logic                   i_sys_clk,
    input  logic                   i_sys_rst,
    input  logic                   i_vga_req,
    input  logic [SRAM_AW-1:0]     i_vga_addr,
    output logic                   o_vga_gnt,
    output logic [SRAM_DW-1:0]     o_vga_rdata,
    output logic                   o_vga_rvalid,
    input  logic                   i_src_req,
    input  logic                   i_src_we,
    input  logic [SRAM_AW-1:0]     i_src_addr,
    input  logic [SRAM_DW/8-1:0]   i_src_be,
    input  logic [SRAM_DW-1:0]     i_src_wdata,
    output logic                   o_src_gnt,
    output logic [SRAM_DW-1:0]     o_src_rdata,
    output logic                   o_src_rvalid,
    output logic                   o_sram_ce_n,
    output logic                   o_sram_oe_n,
    output logic                   o_sram_we_n,
    output logic [SRAM_DW/8-1:0]   o_sram_be_n,
    output logic [SRAM_AW-1:0]     o_sram_addr,
    output logic [SRAM_DW-1:0]     o_sram_dq_write,
    output logic                   o_sram_dq_en,
    input  logic [SRAM_DW-1:0]     i_sram_dq_read
);
    localparam int CW = $clog2(ACCESS_CYCLES + 1);
    localparam int SW = $clog2(VGA_MAX_STREAK + 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(ACCESS_CYCLES - 1);
    localparam logic [CW-1:0] CNT_WE_OFF = CW'(ACCESS_CYCLES - 2);
    localparam logic [SW-1:0] STREAK_MAX = SW'(VGA_MAX_STREAK);

    typedef enum logic {ST_IDLE, ST_ACCESS} state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [SW-1:0]   r_streak;
    logic            r_is_vga;
    logic            r_is_write;

    logic            w_decide;
    logic            w_grant_vga;
    logic            w_grant_src;

    function automatic logic [SW-1:0] streak_inc(input logic [SW-1:0] s);
        return (s == STREAK_MAX) ? s : s + SW'(1);
    endfunction

    // Decisions happen only while idle or on the final cycle of an access.
    assign w_decide    = (r_state == ST_IDLE) || (r_cnt == CNT_LAST);
    assign w_grant_vga = i_vga_req && !(i_src_req && (r_streak == STREAK_MAX));
    assign w_grant_src = i_src_req && !w_grant_vga;

    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            r_state         <= ST_IDLE;
            r_cnt           <= '0;
            r_streak        <= '0;
            r_is_vga        <= 1'b0;
            r_is_write      <= 1'b0;
            o_vga_gnt       <= 1'b0;
            o_vga_rdata     <= '0;
            o_vga_rvalid    <= 1'b0;
            o_src_gnt       <= 1'b0;
            o_src_rdata     <= '0;
            o_src_rvalid    <= 1'b0;
            o_sram_ce_n     <= 1'b1;
            o_sram_oe_n     <= 1'b1;
            o_sram_we_n     <= 1'b1;
            o_sram_be_n     <= '1;
            o_sram_addr     <= '0;
            o_sram_dq_write <= '0;
            o_sram_dq_en    <= 1'b0;
        end else begin
            o_vga_gnt    <= 1'b0;
            o_src_gnt    <= 1'b0;
            o_vga_rvalid <= 1'b0;
            o_src_rvalid <= 1'b0;

            if (r_state == ST_ACCESS) begin
                // Release we_n one cycle early so data/addr hold past the write strobe.
                if (r_is_write && (r_cnt == CNT_WE_OFF))
                    o_sram_we_n <= 1'b1;
                if (r_cnt != CNT_LAST) begin
                    r_cnt <= r_cnt + CW'(1);
                end else if (!r_is_write) begin
                    if (r_is_vga) begin
                        o_vga_rdata  <= i_sram_dq_read;
                        o_vga_rvalid <= 1'b1;
                    end else begin
                        o_src_rdata  <= i_sram_dq_read;
                        o_src_rvalid <= 1'b1;
                    end
                end
            end

            if (w_decide) begin
                if (!i_src_req)
                    r_streak <= '0;
                if (w_grant_vga) begin
                    if (i_src_req)
                        r_streak <= streak_inc(r_streak);
                    r_state      <= ST_ACCESS;
                    r_cnt        <= '0;
                    r_is_vga     <= 1'b1;
                    r_is_write   <= 1'b0;
                    o_vga_gnt    <= 1'b1;
                    o_sram_ce_n  <= 1'b0;
                    o_sram_oe_n  <= 1'b0;
                    o_sram_we_n  <= 1'b1;
                    o_sram_be_n  <= '0;
                    o_sram_addr  <= i_vga_addr;
                    o_sram_dq_en <= 1'b0;
                end else if (w_grant_src) begin
                    r_streak    <= '0;
                    r_state     <= ST_ACCESS;
                    r_cnt       <= '0;
                    r_is_vga    <= 1'b0;
                    r_is_write  <= i_src_we;
                    o_src_gnt   <= 1'b1;
                    o_sram_ce_n <= 1'b0;
                    o_sram_addr <= i_src_addr;
                    if (i_src_we) begin
                        o_sram_oe_n     <= 1'b1;
                        o_sram_we_n     <= 1'b0;
                        o_sram_be_n     <= ~i_src_be;
                        o_sram_dq_write <= i_src_wdata;
                        o_sram_dq_en    <= 1'b1;
                    end else begin
                        o_sram_oe_n  <= 1'b0;
                        o_sram_we_n  <= 1'b1;
                        o_sram_be_n  <= '0;
                        o_sram_dq_en <= 1'b0;
                    end
                end else begin
                    r_state      <= ST_IDLE;
                    o_sram_ce_n  <= 1'b1;
                    o_sram_oe_n  <= 1'b1;
                    o_sram_we_n  <= 1'b1;
                    o_sram_be_n  <= '1;
                    o_sram_dq_en <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_vga_sram_arbiter.sv
// Scoreboard bench: drivers push expected read data from a reference memory, a monitor
// pops on rvalid; grant timing and starvation are checked from a grant log.
module tb_vga_sram_arbiter;
    localparam int AW = 18;
    localparam int DW = 16;
    localparam int MEMSZ = 1 << AW;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // DUT (ACCESS_CYCLES=2) signals
    logic          vga_req, vga_gnt, vga_rvalid;
    logic [AW-1:0] vga_addr;
    logic [DW-1:0] vga_rdata;
    logic          src_req, src_we, src_gnt, src_rvalid;
    logic [AW-1:0] src_addr;
    logic [1:0]    src_be;
    logic [DW-1:0] src_wdata, src_rdata;
    logic          ce_n, oe_n, we_n, dq_en;
    logic [1:0]    be_n;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] dq_write, dq_read;

    // Second DUT (ACCESS_CYCLES=3), VGA port only
    logic          vga_req3, vga_gnt3, vga_rvalid3;
    logic [AW-1:0] vga_addr3;
    logic [DW-1:0] vga_rdata3;
    logic          src_gnt3, src_rvalid3;
    logic [DW-1:0] src_rdata3;
    logic          ce3_n, oe3_n, we3_n, dq_en3;
    logic [1:0]    be3_n;
    logic [AW-1:0] sram_addr3;
    logic [DW-1:0] dq_write3, dq_read3;
    logic          zero1 = 1'b0;
    logic [AW-1:0] zero_a = '0;
    logic [1:0]    zero_be = '0;
    logic [DW-1:0] zero_d = '0;

    vga_sram_arbiter dut (
        .i_sys_clk(clk), .i_sys_rst(rst),
        .i_vga_req(vga_req), .i_vga_addr(vga_addr), .o_vga_gnt(vga_gnt),
        .o_vga_rdata(vga_rdata), .o_vga_rvalid(vga_rvalid),
        .i_src_req(src_req), .i_src_we(src_we), .i_src_addr(src_addr), .i_src_be(src_be),
        .i_src_wdata(src_wdata), .o_src_gnt(src_gnt), .o_src_rdata(src_rdata),
        .o_src_rvalid(src_rvalid), .o_sram_ce_n(ce_n), .o_sram_oe_n(oe_n), .o_sram_we_n(we_n),
        .o_sram_be_n(be_n), .o_sram_addr(sram_addr), .o_sram_dq_write(dq_write),
        .o_sram_dq_en(dq_en), .i_sram_dq_read(dq_read));

    vga_sram_arbiter #(.ACCESS_CYCLES(3)) dut3 (
        .i_sys_clk(clk), .i_sys_rst(rst),
        .i_vga_req(vga_req3), .i_vga_addr(vga_addr3), .o_vga_gnt(vga_gnt3),
        .o_vga_rdata(vga_rdata3), .o_vga_rvalid(vga_rvalid3),
        .i_src_req(zero1), .i_src_we(zero1), .i_src_addr(zero_a), .i_src_be(zero_be),
        .i_src_wdata(zero_d), .o_src_gnt(src_gnt3), .o_src_rdata(src_rdata3),
        .o_src_rvalid(src_rvalid3), .o_sram_ce_n(ce3_n), .o_sram_oe_n(oe3_n), .o_sram_we_n(we3_n),
        .o_sram_be_n(be3_n), .o_sram_addr(sram_addr3), .o_sram_dq_write(dq_write3),
        .o_sram_dq_en(dq_en3), .i_sram_dq_read(dq_read3));

    int checks = 0;
    int errors = 0;
    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Frame-buffer contents before any write
    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        if (a == 18'h00123) return 16'hBEEF;
        return (a[15:0] ^ 16'h5A5A) + {14'h0, a[17:16]};
    endfunction
    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                            input logic [1:0] be);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < 2; b++) if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    // SRAM pin model
    logic [DW-1:0] mem [0:MEMSZ-1];
    bit            mem_v [0:MEMSZ-1];
    function automatic logic [DW-1:0] sram_rd(input logic [AW-1:0] a);
        return mem_v[a] ? mem[a] : init_val(a);
    endfunction
    assign dq_read  = (!ce_n && !oe_n)   ? sram_rd(sram_addr)  : 16'hDEAD;
    assign dq_read3 = (!ce3_n && !oe3_n) ? sram_rd(sram_addr3) : 16'hDEAD;
    always @(posedge clk) begin
        if (!ce_n && !we_n) begin
            mem[sram_addr]   <= merge(sram_rd(sram_addr), dq_write, ~be_n);
            mem_v[sram_addr] <= 1'b1;
        end
    end

    // Reference memory, updated in source-issue order
    logic [DW-1:0] ref_mem [0:MEMSZ-1];
    bit            ref_v [0:MEMSZ-1];
    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        return ref_v[a] ? ref_mem[a] : init_val(a);
    endfunction

    logic [DW-1:0] vga_exp[$], src_exp[$], vga3_exp[$];
    typedef struct { int c; bit v; } gl_t;
    gl_t gnt_log[$];

    // Monitor
    initial begin
        int run = 0;
        bit prev_src_req = 1'b0;
        int last_rv3 = -1;
        logic [DW-1:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                run = 0;
                prev_src_req = 1'b0;
            end else begin
                if (vga_rvalid) begin
                    if (vga_exp.size() == 0) chk("vga_rvalid_unexpected", 1, 0);
                    else begin e = vga_exp.pop_front(); chk("vga_rdata", vga_rdata, e); end
                end
                if (src_rvalid) begin
                    if (src_exp.size() == 0) chk("src_rvalid_unexpected", 1, 0);
                    else begin e = src_exp.pop_front(); chk("src_rdata", src_rdata, e); end
                end
                if (vga_gnt || src_gnt) begin
                    chk("single_gnt", {31'd0, vga_gnt && src_gnt}, 0);
                    gnt_log.push_back('{cyc, vga_gnt});
                end
                if (vga_gnt) begin
                    run = prev_src_req ? run + 1 : 0;
                    chk("vga_streak_bound", {31'd0, run <= 4}, 1);
                end
                if (src_gnt) run = 0;
                prev_src_req = src_req;
                if (vga_rvalid3) begin
                    if (vga3_exp.size() == 0) chk("vga3_rvalid_unexpected", 1, 0);
                    else begin e = vga3_exp.pop_front(); chk("vga3_rdata", vga_rdata3, e); end
                    if (last_rv3 >= 0) chk("vga3_rvalid_interval", cyc - last_rv3, 3);
                    last_rv3 = cyc;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic vga_read(input logic [AW-1:0] a, input bit keep);
        int n = 0;
        vga_req = 1'b1; vga_addr = a;
        vga_exp.push_back(ref_rd(a));
        while (n < 100) begin @(negedge clk); if (vga_gnt) break; n++; end
        chk("vga_gnt_wait", {31'd0, n < 100}, 1);
        tick();
        if (!keep) vga_req = 1'b0;
    endtask

    task automatic src_op(input bit we, input logic [AW-1:0] a, input logic [1:0] be,
                          input logic [DW-1:0] wd, input bit keep);
        int n = 0;
        src_req = 1'b1; src_we = we; src_addr = a; src_be = be; src_wdata = wd;
        if (we) begin ref_mem[a] = merge(ref_rd(a), wd, be); ref_v[a] = 1'b1; end
        else src_exp.push_back(ref_rd(a));
        while (n < 100) begin @(negedge clk); if (src_gnt) break; n++; end
        chk("src_gnt_wait", {31'd0, n < 100}, 1);
        tick();
        if (!keep) src_req = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, issue_c, src_c, nv, c0;
        rst = 1'b1;
        vga_req = 0; vga_addr = '0; src_req = 0; src_we = 0; src_addr = '0; src_be = '0;
        src_wdata = '0; vga_req3 = 0; vga_addr3 = '0;
        for (int i = 0; i < MEMSZ; i++) begin mem_v[i] = 1'b0; ref_v[i] = 1'b0; end
        #22;
        chk("rst_ctrl", {ce_n, oe_n, we_n, be_n, dq_en}, 6'b111110);
        chk("rst_addr", sram_addr, 0);
        chk("rst_dq_write", dq_write, 0);
        chk("rst_pulses", {vga_gnt, src_gnt, vga_rvalid, src_rvalid}, 0);
        chk("rst_rdata", {vga_rdata, src_rdata}, 0);
        rst = 1'b0;
        repeat (2) tick();

        // Reset during a write
        src_req = 1; src_we = 1; src_addr = 18'h3FF00; src_be = 2'b11; src_wdata = 16'h1234;
        @(negedge clk); @(negedge clk);
        chk("t1_gnt_before_rst", {src_gnt, we_n}, 2'b10);
        #2 rst = 1'b1; #1;
        chk("t1_ctrl_in_rst", {ce_n, oe_n, we_n, be_n, dq_en, src_gnt}, 7'b1111100);
        src_req = 0;
        @(negedge clk); #2 rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("t1_post_rst_quiet", {src_gnt, src_rvalid, ce_n}, 3'b001);
        end
        tick();

        // VGA read of 0x00123
        fork
            vga_read(18'h00123, 0);
            begin
                @(negedge clk); chk("t2_no_gnt_yet", vga_gnt, 0);
                @(negedge clk);
                chk("t2_gnt", vga_gnt, 1);
                chk("t2_ctrl1", {ce_n, oe_n, we_n, be_n, dq_en}, 6'b001000);
                chk("t2_addr", sram_addr, 18'h00123);
                @(negedge clk); chk("t2_ctrl2", {vga_gnt, ce_n, oe_n}, 3'b000);
                @(negedge clk); chk("t2_rvalid", {vga_rvalid, ce_n}, 2'b11);
                chk("t2_rdata", vga_rdata, 16'hBEEF);
            end
        join
        repeat (2) tick();

        // Source write 0x3FFFF, partial byte enable, then read back
        fork
            src_op(1, 18'h3FFFF, 2'b10, 16'hA55A, 0);
            begin
                @(negedge clk); @(negedge clk);
                chk("t3_gnt", src_gnt, 1);
                chk("t3_ctrl1", {ce_n, oe_n, we_n, be_n, dq_en}, 6'b010011);
                chk("t3_addr_data", {sram_addr, dq_write}, {18'h3FFFF, 16'hA55A});
                @(negedge clk); chk("t3_ctrl2", {ce_n, we_n, be_n, dq_en}, 5'b01011);
                @(negedge clk); chk("t3_end", {ce_n, dq_en, src_rvalid}, 3'b100);
            end
        join
        src_op(0, 18'h3FFFF, 2'b11, 16'h0, 0);
        repeat (4) tick();

        // Starvation guard with VGA streaming
        base = gnt_log.size();
        issue_c = 0;
        fork
            for (int i = 0; i < 10; i++) vga_read(18'($urandom_range(0, 18'h1FFFF)), i < 9);
            begin
                int n = 0;
                while (n < 100) begin @(negedge clk); if (vga_gnt) break; n++; end
                tick();
                issue_c = cyc;
                src_op(0, 18'h20003, 2'b11, 16'h0, 0);
            end
        join
        repeat (4) tick();
        src_c = -1; nv = 0;
        for (int i = base; i < gnt_log.size(); i++)
            if (!gnt_log[i].v && src_c < 0) src_c = gnt_log[i].c;
        for (int i = base; i < gnt_log.size(); i++)
            if (gnt_log[i].v && gnt_log[i].c > issue_c && (src_c < 0 || gnt_log[i].c < src_c)) nv++;
        chk("t4_vga_before_src", nv, 4);
        chk("t4_total_gnts", gnt_log.size() - base, 11);
        for (int i = base + 1; i < gnt_log.size(); i++)
            chk("t4_back_to_back", gnt_log[i].c - gnt_log[i-1].c, 2);
        for (int i = base; i < gnt_log.size(); i++)
            if (src_c >= 0 && gnt_log[i].c == src_c + 2) chk("t4_vga_resumes", gnt_log[i].v, 1);

        // Simultaneous request from idle
        base = gnt_log.size();
        c0 = cyc;
        fork
            vga_read(18'h00042, 0);
            src_op(0, 18'h20001, 2'b11, 16'h0, 0);
        join
        repeat (3) tick();
        chk("t5_gnt_count", gnt_log.size() - base, 2);
        if (gnt_log.size() - base == 2) begin
            chk("t5_first_vga", {gnt_log[base].v, 32'(gnt_log[base].c - c0)}, {1'b1, 32'd1});
            chk("t5_then_src", {gnt_log[base+1].v, 32'(gnt_log[base+1].c - c0)}, {1'b0, 32'd3});
        end

        // Random concurrent traffic
        fork
            for (int i = 0; i < 30; i++) begin
                int gap = $urandom_range(0, 3);
                vga_read(18'($urandom_range(0, 18'h1FFFF)), gap == 0);
                repeat (gap) tick();
            end
            for (int i = 0; i < 30; i++) begin
                int gap = $urandom_range(0, 3);
                src_op($urandom_range(0, 1), 18'h20000 | 18'($urandom_range(0, 15)),
                       2'($urandom_range(1, 3)), 16'($urandom), gap == 0);
                repeat (gap) tick();
            end
        join
        repeat (8) tick();
        chk("vga_exp_drained", vga_exp.size(), 0);
        chk("src_exp_drained", src_exp.size(), 0);

        // ACCESS_CYCLES=3 back-to-back VGA reads
        for (int i = 0; i < 6; i++) begin
            int n = 0;
            logic [AW-1:0] a;
            a = 18'($urandom_range(0, 18'h1FFFF));
            vga_req3 = 1'b1; vga_addr3 = a;
            vga3_exp.push_back(init_val(a));
            while (n < 100) begin @(negedge clk); if (vga_gnt3) break; n++; end
            chk("vga3_gnt_wait", {31'd0, n < 100}, 1);
            tick();
        end
        vga_req3 = 1'b0;
        repeat (6) tick();
        chk("vga3_exp_drained", vga3_exp.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
